// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment display path:
// widths, segment bit positions and the status-word glyphs.
package seg_pkg;

  localparam int SEG_W      = 7;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [SEG_W-1:0] seg_t;
  typedef seg_t word_t [NUM_DIGITS];

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_O = 7'h5C;
  localparam seg_t GLYPH_L = 7'h38;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_R = 7'h50;
  localparam seg_t GLYPH_P = 7'h73;
  localparam seg_t GLYPH_H = 7'h76;
  localparam seg_t GLYPH_T = 7'h78;

  // Words are listed leftmost digit first.
  localparam word_t WORD_COLD = '{GLYPH_C, GLYPH_O, GLYPH_L, GLYPH_D};
  localparam word_t WORD_DROP = '{GLYPH_D, GLYPH_R, GLYPH_O, GLYPH_P};
  localparam word_t WORD_HOT  = '{SEG_BLANK, GLYPH_H, GLYPH_O, GLYPH_T};

  // Active-low anode pattern selecting one digit; digit1 sits on the MSB.
  function automatic logic [NUM_DIGITS-1:0] anode_n(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] a;
    a = '1;
    a[IDX_W'(NUM_DIGITS-1) - idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timer: counts DIV cycles per slot and steps the digit index
// 0..3; flags the last cycle of a slot and the leading blank gap.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_wrap,
  output logic             blank_phase,
  output logic [IDX_W-1:0] index
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      index <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      index <= index + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_wrap = (cnt == LAST);

  generate
    if (BLANK == 0) begin : g_no_gap
      assign blank_phase = 1'b0;
    end else begin : g_gap
      assign blank_phase = (cnt < CNT_W'(BLANK));
    end
  endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with shadow registers,
// deghosting blank gap and frame pulse. Optional blink via SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 25
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg1_in,
  input  logic [SEG_W-1:0]      seg2_in,
  input  logic [SEG_W-1:0]      seg3_in,
  input  logic [SEG_W-1:0]      seg4_in,
  input  logic                  upd,
  input  logic                  en,
`ifdef SEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  logic             slot_wrap;
  logic             blank_phase;
  logic [IDX_W-1:0] index;
  logic             frame_evt;
  logic             visible;
  logic             dark;
  seg_t             shadow [NUM_DIGITS];

  seg_slot_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_wrap   (slot_wrap),
    .blank_phase (blank_phase),
    .index       (index)
  );

  assign frame_evt = slot_wrap && (index == IDX_W'(NUM_DIGITS - 1));

  // upd is a single-cycle strobe with no back-pressure: all four shadows
  // load together on any edge where it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_BLANK;
    end else if (upd) begin
      shadow[0] <= seg1_in;
      shadow[1] <= seg2_in;
      shadow[2] <= seg3_in;
      shadow[3] <= seg4_in;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visible   <= 1'b1;
      frame_cnt <= '0;
    end else if (!blink) begin
      visible   <= 1'b1;
      frame_cnt <= '0;
    end else if (frame_evt) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  assign dark = !en || !visible || blank_phase;

  // Outputs lag the timer by one cycle, so frame_done stays aligned with
  // the last displayed cycle of the digit4 slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= ~SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an_n       <= dark ? '1 : anode_n(index);
      seg_n      <= dark ? ~SEG_BLANK : ~shadow[index];
      frame_done <= frame_evt;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Physical-display end of the four-digit seven-segment interface produced by the baggage-drop status logic (Cold/Drop/Hot glyphs). Captures four 7-bit active-high segment patterns into shadow registers on an update strobe. Time-multiplexes them onto one shared, active-low segment bus with active-low digit anodes, inserting a deghosting blank gap before each digit. Emits a frame-boundary pulse so the producer can update between frames.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range DIV >= 2
BLANK, 1000, cycles at the start of each slot with all anodes off; legal range 0 <= BLANK < DIV

Ports:
clk  input  1  system clock; the only clock
rst_n  input  1  asynchronous, active-low reset
seg1_in  input  7  leftmost digit pattern; bit0 = a ... bit6 = g; 1 = segment lit
seg2_in  input  7  digit 2 pattern
seg3_in  input  7  digit 3 pattern
seg4_in  input  7  rightmost digit pattern
upd  input  1  capture all four seg*_in into shadow registers this edge
en  input  1  display enable; 0 forces the display dark
seg_n  output  7  shared segment bus, active-low (~pattern)
an_n  output  4  anodes, active-low; an_n[3] = digit1 ... an_n[0] = digit4
frame_done  output  1  one-cycle pulse on the last cycle of the digit4 slot

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - shadow registers = 0; slot counter = 0; digit index = 0 (digit1).
  - an_n = 4'b1111; seg_n = 7'h7F; frame_done = 0.
- Shadow capture: if upd = 1 at an edge, all four shadows load atomically at that edge. Otherwise the inputs are ignored.
- Slot counter:
  - Counts 0..DIV-1 and wraps to 0.
  - On wrap, the digit index advances 0 → 1 → 2 → 3 → 0.
  - Scan order is digit1, digit2, digit3, digit4.
- All outputs are registered. The values driven in cycle t+1 are computed from the counter, index and shadow state as they stand after edge t.
- Within a slot:
  - Counter < BLANK: an_n = 1111, seg_n = 7F.
  - Otherwise: the anode of the current digit is low and seg_n = ~shadow[index].
  - BLANK = 0 means no gap.
- A shadow update during an active phase appears on seg_n the cycle after the capture edge. No tearing control is applied beyond this; producers use frame_done to update on frame boundaries.
- en = 0: outputs go dark (an_n = 1111, seg_n = 7F) from the next cycle. The counter, index and frame_done keep running. When en returns to 1, the scan resumes in its current position with no restart.
- frame_done: high for exactly one cycle when index = 3 and counter = DIV-1. The period is 4*DIV cycles and is independent of en and upd.
- Reset released mid-scan: the scan restarts at digit1, counter 0, in the blank phase.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - Adds input blink (1 bit) and parameter BLINK_FRAMES (default 25, must be >= 1).
  - While blink = 1, a frame counter toggles a visibility flag every BLINK_FRAMES frame_done pulses. When the flag is off, outputs are dark exactly as for en = 0.
  - When blink = 0, the flag is forced visible and the frame counter is cleared.
  - Reset state: visible, count 0.
- Not defined: no blink port, no counter logic; the display never blinks.

Decomposition:
- Package seg_pkg holds:
  - SEG_W = 7 and NUM_DIGITS = 4.
  - Segment bit-index constants SEG_A..SEG_G.
  - SEG_BLANK = 7'h00.
  - Glyph constants for the status words: Cold (39,5C,38,5E), Drop (5E,50,5C,73), Hot (00,76,5C,78).
- One sub-module: seg_slot_timer. It is the DIV slot counter plus digit index, outputs slot_wrap, blank_phase and index.

Test Plan:
1. Reset and release (DIV=4, BLANK=1):
   - Hold rst_n = 0 → an_n = 1111, seg_n = 7F, frame_done = 0.
   - Release with no upd → all slots dark, since shadows are 0.
2. Drop word:
   - Pulse upd with Drop (5E,50,5C,73), en = 1.
   - Digit1 slot: 1 cycle an_n = 1111, then 3 cycles an_n = 0111, seg_n = 21.
   - Digit2 slot: an_n = 1011, seg_n = 2F.
   - Digit3 slot: an_n = 1101, seg_n = 23.
   - Digit4 slot: an_n = 1110, seg_n = 0C.
3. frame_done:
   - Exactly one pulse every 16 cycles, coincident with the last digit4 cycle.
   - Periodicity is unchanged while en toggles.
4. Update mid-slot:
   - Change inputs to Hot with upd = 0 → no output change.
   - Assert upd during the digit2 active phase → seg_n = 09 on the next cycle.
5. Disable:
   - en = 0 during digit3 → an_n = 1111, seg_n = 7F next cycle.
   - Restore after 6 cycles → resumes at the correct slot position.
6. Reset mid-scan:
   - Assert rst_n low during digit4 → outputs dark immediately, without waiting for a clock.
   - After release → restart at digit1 blank phase.
   - Blink (with SEG_BLINK_EN, BLINK_FRAMES = 2) → display dark for 2 frames, then lit for 2.
